// File: rtl/nx_axi4s_packer.sv
// -----------------------------------------------------------------------------
// nx_axi4s_packer
//
// Packs narrow messages into wide AXI4-stream beats. Messages fill a build
// register slot by slot (slot 0 in the least significant bits). A build is
// closed when its last slot fills, when a message carries i_msg_last, or when
// a partially filled build has sat idle for FLUSH_CYCLES edges. A closed
// build moves into a single output register, which holds the beat stable
// until the consumer takes it. Unused slots of a partial beat read as zero.
//
// Parameters
//   AXI4_DATA_WIDTH  outbound beat width (integer multiple of MSG_WIDTH)
//   MSG_WIDTH        message width
//   FLUSH_CYCLES     idle edges before a partial beat is flushed; 0 = never
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   i_msg_data       message payload
//   i_msg_last       final message of a frame (closes the build)
//   i_msg_valid      message valid
//   o_msg_ready      message ready
//   o_tdata          beat data
//   o_tlast          beat last
//   o_tvalid         beat valid
//   i_tready         beat ready
//   o_idle           no message held anywhere in the block
// -----------------------------------------------------------------------------
module nx_axi4s_packer #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int MSG_WIDTH       = 32,
  parameter int FLUSH_CYCLES    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MSG_WIDTH-1:0]       i_msg_data,
  input  logic                       i_msg_last,
  input  logic                       i_msg_valid,
  output logic                       o_msg_ready,
  output logic [AXI4_DATA_WIDTH-1:0] o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       i_tready,
  output logic                       o_idle
);

  localparam int SLOTS = AXI4_DATA_WIDTH / MSG_WIDTH;
  localparam int CW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FW    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  logic [AXI4_DATA_WIDTH-1:0] build_q, build_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       pending_q, pending_d;
  logic                       pend_last_q, pend_last_d;
  logic [FW-1:0]              flush_q, flush_d;

  logic [AXI4_DATA_WIDTH-1:0] tdata_q;
  logic                       tlast_q;
  logic                       tvalid_q;

  logic out_free;
  logic xfer;
  logic accept;

  assign out_free    = !tvalid_q || i_tready;
  assign xfer        = pending_q && out_free;
  // While pending, the only way to take a message is to hand the closed build
  // to the output register on the same edge, so the message starts a fresh one.
  assign o_msg_ready = !pending_q || out_free;
  assign accept      = i_msg_valid && o_msg_ready;

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_idle   = (count_q == '0) && !pending_q && !tvalid_q;

  // Build-side next state. A transfer first empties the build; an accepted
  // message is then written on top of that, landing in slot 0 of the new build.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    build_d     = xfer ? '0 : build_q;
    count_d     = xfer ? '0 : count_q;
    pending_d   = pending_q && !xfer;
    pend_last_d = pend_last_q;
    flush_d     = flush_q;

    if (accept) begin
      build_d[count_d*MSG_WIDTH +: MSG_WIDTH] = i_msg_data;
      flush_d = '0;
      if (count_d == CW'(SLOTS - 1) || i_msg_last) begin
        // Closing message: tlast follows the message, even if the flush
        // timer would have expired on this same edge.
        pending_d   = 1'b1;
        pend_last_d = i_msg_last;
        count_d     = '0;
      end else begin
        count_d = count_d + 1'b1;
      end
    end else if (FLUSH_CYCLES != 0 && count_q != '0 && !pending_q) begin
      // Partial build sitting idle: close it once enough edges have passed.
      if (flush_q == FW'(FLUSH_CYCLES - 1)) begin
        pending_d   = 1'b1;
        pend_last_d = 1'b1;
        flush_d     = '0;
      end else begin
        flush_d = flush_q + 1'b1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      build_q     <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      pend_last_q <= 1'b0;
      flush_q     <= '0;
    end else begin
      build_q     <= build_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      pend_last_q <= pend_last_d;
      flush_q     <= flush_d;
    end
  end

  // Output register: loads only when free, so a stalled beat holds still.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (xfer) begin
      tdata_q  <= build_q;
      tlast_q  <= pend_last_q;
      tvalid_q <= 1'b1;
    end else if (i_tready) begin
      tvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nx_axi4s_packer.sv
// -----------------------------------------------------------------------------
// tb_nx_axi4s_packer
//
// Directed bench for nx_axi4s_packer with default parameters (128-bit beats,
// 32-bit messages, flush after 16 idle edges). Inputs change 1 ns after the
// rising edge; outputs are read on the falling edge. A monitor records every
// beat that transfers so drained streams can be compared against expected
// beats built from the messages sent.
// -----------------------------------------------------------------------------
module tb_nx_axi4s_packer;

  localparam int W = 128;
  localparam int M = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [M-1:0] i_msg_data  = '0;
  logic         i_msg_last  = 1'b0;
  logic         i_msg_valid = 1'b0;
  logic         i_tready    = 1'b0;
  logic         o_msg_ready;
  logic [W-1:0] o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_idle;

  nx_axi4s_packer #(
    .AXI4_DATA_WIDTH(W),
    .MSG_WIDTH      (M),
    .FLUSH_CYCLES   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_msg_data (i_msg_data),
    .i_msg_last (i_msg_last),
    .i_msg_valid(i_msg_valid),
    .o_msg_ready(o_msg_ready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .i_tready   (i_tready),
    .o_idle     (o_idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Beats seen leaving the DUT.
  logic [W-1:0] bq_data[$];
  logic         bq_last[$];

  always @(negedge clk) begin
    if (!rst && o_tvalid && i_tready) begin
      bq_data.push_back(o_tdata);
      bq_last.push_back(o_tlast);
    end
  end

  function automatic logic [W-1:0] pack4(input logic [M-1:0] a, input logic [M-1:0] b,
                                          input logic [M-1:0] c, input logic [M-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one message for exactly one cycle (caller guarantees ready).
  task automatic send(input logic [M-1:0] data, input logic last);
    i_msg_valid = 1'b1;
    i_msg_data  = data;
    i_msg_last  = last;
    tick();
    i_msg_valid = 1'b0;
    i_msg_last  = 1'b0;
  endtask

  int          n_acc;
  int          lows;
  int          early;
  logic        acc;
  logic [M-1:0] b;

  initial begin
    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_ready", o_msg_ready, 1);
    check("rst_idle", o_idle, 1);
    tick();
    rst = 1'b0;
    tick();

    // ---------------- full beat, latency of one cycle ----------------
    bq_data.delete(); bq_last.delete();
    i_tready = 1'b1;
    i_msg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_msg_data = M'(32'h11 * (i + 1));
      tick();
    end
    i_msg_valid = 1'b0;
    @(negedge clk);
    check("full_no_early", o_tvalid, 0);
    tick();
    @(negedge clk);
    check("full_tvalid", o_tvalid, 1);
    check("full_tdata", o_tdata, pack4(32'h11, 32'h22, 32'h33, 32'h44));
    check("full_tlast", o_tlast, 0);
    tick();
    @(negedge clk);
    check("full_count", bq_data.size(), 1);
    check("full_idle", o_idle, 1);

    // ---------------- partial beat closed by last ----------------
    tick();
    bq_data.delete(); bq_last.delete();
    send(32'hA1, 1'b0);
    send(32'hA2, 1'b1);
    tick();
    @(negedge clk);
    check("last_tvalid", o_tvalid, 1);
    check("last_tdata", o_tdata, pack4(32'hA1, 32'hA2, 32'h0, 32'h0));
    check("last_tlast", o_tlast, 1);
    tick();

    // ---------------- flush timeout ----------------
    tick();
    send(32'h5, 1'b0);
    // The message edge is followed by 16 idle edges that close the build,
    // then one more edge to load the output register.
    early = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (o_tvalid) early++;
      if (k < 16) tick();
    end
    check("flush_no_early", early, 0);
    check("flush_not_idle", o_idle, 0);
    tick();
    @(negedge clk);
    check("flush_tvalid", o_tvalid, 1);
    check("flush_tdata", o_tdata, pack4(32'h5, 32'h0, 32'h0, 32'h0));
    check("flush_tlast", o_tlast, 1);
    tick();

    // ---------------- backpressure ----------------
    tick();
    bq_data.delete(); bq_last.delete();
    i_tready    = 1'b0;
    n_acc       = 0;
    i_msg_valid = 1'b1;
    i_msg_data  = 32'h100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = o_msg_ready;
      tick();
      if (acc) begin
        n_acc++;
        i_msg_data = M'(32'h100 + n_acc);
      end
    end
    @(negedge clk);
    check("bp_accepted", n_acc, 8);
    check("bp_ready_low", o_msg_ready, 0);
    check("bp_tvalid", o_tvalid, 1);
    check("bp_tdata", o_tdata, pack4(32'h100, 32'h101, 32'h102, 32'h103));
    repeat (3) @(negedge clk);
    check("bp_tdata_stable", o_tdata, pack4(32'h100, 32'h101, 32'h102, 32'h103));
    check("bp_tvalid_stable", o_tvalid, 1);
    tick();
    i_tready = 1'b1;
    for (int c = 0; c < 20 && n_acc < 12; c++) begin
      @(negedge clk);
      acc = o_msg_ready;
      tick();
      if (acc) begin
        n_acc++;
        i_msg_data = M'(32'h100 + n_acc);
        if (n_acc == 12) i_msg_valid = 1'b0;
      end
    end
    i_msg_valid = 1'b0;
    check("bp_total_acc", n_acc, 12);
    repeat (6) tick();
    @(negedge clk);
    check("bp_beats", bq_data.size(), 3);
    for (int j = 0; j < 3 && j < bq_data.size(); j++) begin
      b = M'(32'h100 + 4 * j);
      check($sformatf("bp_beat%0d", j), bq_data[j], pack4(b, b + 1, b + 2, b + 3));
      check($sformatf("bp_last%0d", j), bq_last[j], 0);
    end
    check("bp_idle", o_idle, 1);

    // ---------------- full throughput ----------------
    tick();
    bq_data.delete(); bq_last.delete();
    lows = 0;
    i_msg_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      i_msg_data = M'(32'h1000 + i);
      @(negedge clk);
      if (!o_msg_ready) lows++;
      tick();
    end
    i_msg_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("tp_ready_lows", lows, 0);
    check("tp_beats", bq_data.size(), 16);
    for (int j = 0; j < 16 && j < bq_data.size(); j++) begin
      b = M'(32'h1000 + 4 * j);
      check($sformatf("tp_beat%0d", j), bq_data[j], pack4(b, b + 1, b + 2, b + 3));
    end

    // ---------------- mid-operation reset ----------------
    tick();
    send(32'hC1, 1'b0);
    send(32'hC2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_idle", o_idle, 1);
    check("mrst_tvalid", o_tvalid, 0);
    check("mrst_ready", o_msg_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    bq_data.delete(); bq_last.delete();
    send(32'hD1, 1'b0);
    send(32'hD2, 1'b0);
    send(32'hD3, 1'b0);
    send(32'hD4, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("mrst_beats", bq_data.size(), 1);
    if (bq_data.size() > 0) begin
      check("mrst_tdata", bq_data[0], pack4(32'hD1, 32'hD2, 32'hD3, 32'hD4));
      check("mrst_tlast", bq_last[0], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_axi4s_packer.md
NX_AXI4S_PACKER -- requirements
Module: nx_axi4s_packer

Interface
REQ-001 SHALL have parameter AXI4_DATA_WIDTH, default 128, the outbound AXI4-stream beat width.
REQ-002 SHALL have parameter MSG_WIDTH, default 32, the message width; SLOTS = AXI4_DATA_WIDTH/MSG_WIDTH (default 4), and AXI4_DATA_WIDTH SHALL be an integer multiple of MSG_WIDTH.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 16, the idle cycles before a partial beat is flushed; 0 disables flushing.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-006 SHALL have port i_msg_data, input, MSG_WIDTH, the message payload.
REQ-007 SHALL have port i_msg_last, input, 1, which marks the final message of a frame.
REQ-008 SHALL have port i_msg_valid, input, 1, the message valid.
REQ-009 SHALL have port o_msg_ready, output, 1, the message ready.
REQ-010 SHALL have port o_tdata, output, AXI4_DATA_WIDTH, the outbound beat data.
REQ-011 SHALL have port o_tlast, output, 1, the outbound beat last.
REQ-012 SHALL have port o_tvalid, output, 1, the outbound beat valid.
REQ-013 SHALL have port i_tready, input, 1, the outbound beat ready.
REQ-014 SHALL have port o_idle, output, 1, high when no message is held anywhere in the block.

Function
REQ-015 SHALL accept a message on a rising edge where i_msg_valid and o_msg_ready are both high; an AXI beat SHALL transfer on an edge where o_tvalid and i_tready are both high.
REQ-016 SHALL hold a build register of SLOTS slots and a slot counter of 0..SLOTS-1; an accepted message SHALL be written to slot[count] at bits [count*MSG_WIDTH +: MSG_WIDTH], and the counter SHALL then increment.
REQ-017 SHALL mark the build "pending" (closed) on the acceptance of a message that fills slot SLOTS-1 or has i_msg_last=1; the beat's tlast SHALL be i_msg_last of that message.
REQ-018 SHALL, when FLUSH_CYCLES>0, count edges where the build is non-empty, not pending and no message is accepted; any acceptance SHALL clear the count; on the count reaching FLUSH_CYCLES, the build SHALL become pending with tlast=1.
REQ-019 SHALL hold unused slots of a partial beat at zero; an all-zero slot means empty to the consumer.
REQ-020 SHALL hold a single output register; "out_free" = !o_tvalid || i_tready.
REQ-021 SHALL, on an edge with pending && out_free, move the build into the output register (o_tvalid=1 next cycle), clear the build, zero the counter and drop pending.
REQ-022 SHALL drive o_msg_ready = !pending || out_free; when the build transfers on an edge, a message accepted on that same edge SHALL land in slot 0 of the fresh build, giving full throughput of one message per cycle.
REQ-023 SHALL give a latency of one cycle: o_tvalid asserts on the edge after the one that made the build pending, provided out_free.
REQ-024 SHALL keep o_tdata, o_tlast and o_tvalid stable while o_tvalid && !i_tready (AXI4-stream rule).
REQ-025 SHALL, if the flush timeout and a closing message coincide, close the build with the message's tlast; the message is accepted, and no second beat is created.
REQ-026 SHALL drive o_idle = (count==0) && !pending && !o_tvalid.

Reset
REQ-027 SHALL, while rst is high, asynchronously clear the build, counter, pending flag, flush timer and output register; o_tvalid=0, o_tlast=0, o_tdata=0, o_msg_ready=1, o_idle=1.
REQ-028 SHALL discard any partially built or held beat on a mid-operation reset; first beat after release contains only post-reset messages.

Verification
REQ-029 SHALL be verified for: messages 0x11,0x22,0x33,0x44 back-to-back, last=0 on all, i_tready=1 -> one beat with o_tdata=0x00000044_00000033_00000022_00000011, o_tlast=0, one cycle after the 4th acceptance.
REQ-030 SHALL be verified for: messages 0xA1,0xA2 with last on 0xA2 -> beat o_tdata=0x0..0_000000A2_000000A1, o_tlast=1.
REQ-031 SHALL be verified for: single message 0x5, then 16 idle cycles (FLUSH_CYCLES=16) -> beat with slot0=0x5, others zero, o_tlast=1; no beat before the timeout.
REQ-032 SHALL be verified for: i_tready=0 and 12 messages offered -> 8 accepted (one beat held, one pending), o_msg_ready=0, o_tdata stable; on raising i_tready, beats drain in order with no loss.
REQ-033 SHALL be verified for: continuous valid, i_tready=1, 64 messages -> 16 beats, one message accepted per cycle, o_msg_ready never low.
REQ-034 SHALL be verified for: rst pulsed after 2 messages accepted -> o_idle=1, o_tvalid=0, and the next 4 messages form a beat containing only those 4.
